// File: rtl/ts_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ts_bus_master                                                   |
// | Purpose  : Initiator for the AY/YM style BDIR/BC/data bus of the           |
// |            Turbosound-FM block. Turns a single-cycle register read/write   |
// |            request into stretched bus phases (select, address, write or    |
// |            read) that a responder with 2-flop synchronisers and a rising   |
// |            edge detector can follow.                                       |
// | Ports    : CLK, RESET_N (async, active low)                                |
// |            REQ/WR/CHIP/FM_ENA/STAT_SEL/ADDR/WDATA  request side            |
// |            BUSY/ACK/ERR/RDATA                      completion side         |
// |            BDIR/BC/DO/DI                           bus side                |
// | Options  : TSM_SEL_CACHE_EN - keep a shadow of the last select byte and    |
// |            skip the select phase when the request matches it.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ts_bus_master #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int RD_SETTLE   = 6
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       REQ,
    input  logic       WR,
    input  logic       CHIP,
    input  logic       FM_ENA,
    input  logic       STAT_SEL,
    input  logic [7:0] ADDR,
    input  logic [7:0] WDATA,
    output logic       BUSY,
    output logic       ACK,
    output logic       ERR,
    output logic [7:0] RDATA,
    output logic       BDIR,
    output logic       BC,
    output logic [7:0] DO,
    input  logic [7:0] DI
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SEL_SETUP = 4'd1;
    localparam logic [3:0] S_SEL_ACT   = 4'd2;
    localparam logic [3:0] S_SEL_GAP   = 4'd3;
    localparam logic [3:0] S_ADR_SETUP = 4'd4;
    localparam logic [3:0] S_ADR_ACT   = 4'd5;
    localparam logic [3:0] S_ADR_GAP   = 4'd6;
    localparam logic [3:0] S_WR_SETUP  = 4'd7;
    localparam logic [3:0] S_WR_ACT    = 4'd8;
    localparam logic [3:0] S_WR_GAP    = 4'd9;
    localparam logic [3:0] S_RD_ACT    = 4'd10;
    localparam logic [3:0] S_RD_GAP    = 4'd11;
    localparam logic [3:0] S_DONE      = 4'd12;

    // Counter reload values: a state lasting N cycles loads N-1 and exits at 0.
    localparam logic [7:0] c_HOLD_LD   = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] c_GAP_LD    = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] c_SETTLE_LD = 8'(RD_SETTLE - 1);

    logic [3:0] r_state;
    logic [7:0] r_cnt;
    logic       r_wr;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_busy;
    logic       r_ack;
    logic       r_err;
    logic [7:0] r_rdata;
    logic       r_bdir;
    logic       r_bc;
    logic [7:0] r_do;

    logic       w_cnt_done;
    logic       w_accept;
    logic       w_addr_bad;
    logic       w_need_sel;
    logic [7:0] w_sel_byte;

    assign w_cnt_done = (r_cnt == 8'd0);
    assign w_accept   = (r_state == S_IDLE) && REQ;
    // 0xF8..0xFF on the address phase would look like a select command.
    assign w_addr_bad = (ADDR[7:3] == 5'b11111);
    assign w_sel_byte = {5'b11111, ~FM_ENA, STAT_SEL, CHIP};

`ifdef TSM_SEL_CACHE_EN
    logic       r_shadow_vld;
    logic [2:0] r_shadow;
    logic [2:0] r_req_sel;
    logic       w_sel_done;

    assign w_sel_done = (r_state == S_SEL_GAP) && w_cnt_done;
    assign w_need_sel = !r_shadow_vld || (r_shadow != {CHIP, FM_ENA, STAT_SEL});

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_shadow_vld <= 1'b0;
            r_shadow     <= 3'b000;
            r_req_sel    <= 3'b000;
        end else begin
            if (w_accept) begin
                r_req_sel <= {CHIP, FM_ENA, STAT_SEL};
            end
            // Shadow only becomes valid once the responder has seen the phase.
            if (w_sel_done) begin
                r_shadow     <= r_req_sel;
                r_shadow_vld <= 1'b1;
            end
        end
    end
`else
    assign w_need_sel = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_wr    <= 1'b0;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 8'h00;
            r_bdir  <= 1'b0;
            r_bc    <= 1'b0;
            r_do    <= 8'h00;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wr    <= WR;
                        r_addr  <= ADDR;
                        r_wdata <= WDATA;
                        r_busy  <= 1'b1;
                        r_cnt   <= 8'd0;
                        if (w_addr_bad) begin
                            r_state <= S_DONE;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (w_need_sel) begin
                            r_state <= S_SEL_SETUP;
                            r_bc    <= 1'b1;
                            r_do    <= w_sel_byte;
                        end else begin
                            r_state <= S_ADR_SETUP;
                            r_bc    <= 1'b1;
                            r_do    <= ADDR;
                        end
                    end
                end
                S_SEL_SETUP: begin
                    r_state <= S_SEL_ACT;
                    r_bdir  <= 1'b1;
                    r_cnt   <= c_HOLD_LD;
                end
                S_SEL_ACT: begin
                    if (w_cnt_done) begin
                        r_state <= S_SEL_GAP;
                        r_bdir  <= 1'b0;
                        r_bc    <= 1'b0;
                        r_cnt   <= c_GAP_LD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_SEL_GAP: begin
                    if (w_cnt_done) begin
                        r_state <= S_ADR_SETUP;
                        r_bc    <= 1'b1;
                        r_do    <= r_addr;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_ADR_SETUP: begin
                    r_state <= S_ADR_ACT;
                    r_bdir  <= 1'b1;
                    r_cnt   <= c_HOLD_LD;
                end
                S_ADR_ACT: begin
                    if (w_cnt_done) begin
                        r_state <= S_ADR_GAP;
                        r_bdir  <= 1'b0;
                        r_bc    <= 1'b0;
                        r_cnt   <= c_GAP_LD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_ADR_GAP: begin
                    if (w_cnt_done) begin
                        if (r_wr) begin
                            r_state <= S_WR_SETUP;
                            r_bc    <= 1'b0;
                            r_do    <= r_wdata;
                            r_cnt   <= 8'd0;
                        end else begin
                            // Read: DO keeps the address, BC alone asks for data.
                            r_state <= S_RD_ACT;
                            r_bc    <= 1'b1;
                            r_cnt   <= c_SETTLE_LD;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_WR_SETUP: begin
                    r_state <= S_WR_ACT;
                    r_bdir  <= 1'b1;
                    r_cnt   <= c_HOLD_LD;
                end
                S_WR_ACT: begin
                    if (w_cnt_done) begin
                        r_state <= S_WR_GAP;
                        r_bdir  <= 1'b0;
                        r_bc    <= 1'b0;
                        r_cnt   <= c_GAP_LD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_WR_GAP, S_RD_GAP: begin
                    if (w_cnt_done) begin
                        r_state <= S_DONE;
                        r_ack   <= 1'b1;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RD_ACT: begin
                    if (w_cnt_done) begin
                        r_rdata <= DI;
                        r_state <= S_RD_GAP;
                        r_bc    <= 1'b0;
                        r_cnt   <= c_GAP_LD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= 8'd0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_bdir  <= 1'b0;
                    r_bc    <= 1'b0;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign BUSY  = r_busy;
    assign ACK   = r_ack;
    assign ERR   = r_err;
    assign RDATA = r_rdata;
    assign BDIR  = r_bdir;
    assign BC    = r_bc;
    assign DO    = r_do;

endmodule
`default_nettype wire
